// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture path: FSM encodings, channel codes
// and the rule that maps the configured resolution onto a usable width.
package i2s_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WS,
        DELAY,
        SHIFT,
        HOLD
    } state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Out-of-range resolutions (0 or wider than the buffer word) fall back to full width.
    function automatic logic [6:0] clamp_res(input logic [5:0] conf, input int unsigned max_w);
        if (conf != 6'd0 && 32'(conf) <= max_w) begin
            return {1'b0, conf};
        end
        return 7'(max_w);
    endfunction

endpackage

// File: rtl/i2s_rx_capture_dpram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module dpram #(
    parameter int DATA_WIDTH = 16,
    parameter int RAM_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [RAM_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [RAM_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**RAM_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S slave receiver: oversamples sck/ws/sd in the wb_clk domain, deserialises
// left/right words and stores them in a circular buffer with half-full events.
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [5:0]            conf_res,
    input  logic                  conf_swap,
    input  logic                  conf_en,
    input  logic                  i2s_sck,
    input  logic                  i2s_ws,
    input  logic                  i2s_sd,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] sample_dat_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic                  evt_lsbf,
    output logic                  evt_hsbf
);

    localparam logic [ADDR_WIDTH-1:0] LOW_LAST  = {1'b0, {(ADDR_WIDTH-1){1'b1}}};
    localparam logic [ADDR_WIDTH-1:0] HIGH_LAST = '1;

    state_t                  state;
    logic [1:0]              sck_pipe, ws_pipe, sd_pipe;
    logic                    sck_last;
    logic                    ws_last;
    logic [6:0]              count;
    logic [DATA_WIDTH-1:0]   shift;
    logic [ADDR_WIDTH-2:0]   pair_ptr;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic                    sck_rise, ws_s, sd_s, ws_change, take_bit;
    logic [6:0]              res, count_nx;
    logic [DATA_WIDTH-1:0]   shift_nx, word;
    logic [ADDR_WIDTH-1:0]   commit_addr;

    // The edge that reveals a ws change also carries the LSB of the ending word,
    // so the bit is shifted in before the word-complete test is made.
    always_comb begin
        sck_rise    = sck_pipe[1] & ~sck_last;
        ws_s        = ws_pipe[1];
        sd_s        = sd_pipe[1];
        ws_change   = ws_s != ws_last;
        res         = clamp_res(conf_res, DATA_WIDTH);
        take_bit    = (state == SHIFT) && (count < res);
        shift_nx    = take_bit ? {shift[DATA_WIDTH-2:0], sd_s} : shift;
        count_nx    = take_bit ? count + 7'd1 : count;
        word        = shift_nx << (7'(DATA_WIDTH) - res);
        commit_addr = {pair_ptr, (ws_last == WS_RIGHT) ^ conf_swap};
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sck_pipe <= '0;
            ws_pipe  <= '0;
            sd_pipe  <= '0;
            sck_last <= 1'b0;
            ws_last  <= WS_LEFT;
            state    <= IDLE;
            count    <= '0;
            shift    <= '0;
            pair_ptr <= '0;
            wr_ptr_o <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            evt_lsbf <= 1'b0;
            evt_hsbf <= 1'b0;
        end else begin
            sck_pipe <= {sck_pipe[0], i2s_sck};
            ws_pipe  <= {ws_pipe[0], i2s_ws};
            sd_pipe  <= {sd_pipe[0], i2s_sd};
            sck_last <= sck_pipe[1];
            wr_en    <= 1'b0;
            evt_lsbf <= 1'b0;
            evt_hsbf <= 1'b0;

            // A write registered last cycle still reaches the buffer when disabled.
            if (!conf_en || state == IDLE) begin
                state    <= conf_en ? WAIT_WS : IDLE;
                ws_last  <= ws_s;
                count    <= '0;
                shift    <= '0;
                pair_ptr <= '0;
                wr_ptr_o <= '0;
            end else if (sck_rise) begin
                ws_last <= ws_s;
                case (state)
                    WAIT_WS: begin
                        if (ws_change) begin
                            state <= DELAY;
                        end
                    end
                    DELAY: begin
                        shift <= {{(DATA_WIDTH-1){1'b0}}, sd_s};
                        count <= 7'd1;
                        state <= (res == 7'd1) ? HOLD : SHIFT;
                    end
                    SHIFT, HOLD: begin
                        shift <= shift_nx;
                        count <= count_nx;
                        if (ws_change) begin
                            state <= DELAY;
                            if (count_nx == res) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= commit_addr;
                                wr_data  <= word;
                                wr_ptr_o <= commit_addr + 1'b1;
                                evt_lsbf <= commit_addr == LOW_LAST;
                                evt_hsbf <= commit_addr == HIGH_LAST;
                                if (commit_addr[0]) begin
                                    pair_ptr <= pair_ptr + 1'b1;
                                end
                            end
                        end else if (count_nx == res) begin
                            state <= HOLD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_WIDTH  (ADDR_WIDTH)
    ) u_buffer (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (sample_dat_o)
    );

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Self-checking bench for i2s_rx_capture: drives an I2S stream at 16x slower
// than wb_clk, queues expected buffer writes and reads them back through the host port.
module tb_i2s_rx_capture;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic [5:0]    conf_res;
    logic          conf_swap, conf_en;
    logic          i2s_sck, i2s_ws, i2s_sd;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] sample_dat_o;
    logic [AW-1:0] wr_ptr_o;
    logic          evt_lsbf, evt_hsbf;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [AW-2:0] mPair;
    logic          mSwap;
    logic          carryBit;
    int            vectors = 0;
    int            miscompares = 0;
    int            lsbfCount = 0;
    int            hsbfCount = 0;
    int            runLen = 0;
    int            maxRun = 0;

    i2s_rx_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .conf_res     (conf_res),
        .conf_swap    (conf_swap),
        .conf_en      (conf_en),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .sample_dat_o (sample_dat_o),
        .wr_ptr_o     (wr_ptr_o),
        .evt_lsbf     (evt_lsbf),
        .evt_hsbf     (evt_hsbf)
    );

    always #5 wb_clk = ~wb_clk;

    // Event pulses are counted and their widths tracked on the inactive edge.
    always @(negedge wb_clk) begin
        if (evt_lsbf) lsbfCount++;
        if (evt_hsbf) hsbfCount++;
        if (evt_lsbf || evt_hsbf) runLen++;
        else runLen = 0;
        if (runLen > maxRun) maxRun = runLen;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sckCycle(input logic wsVal, input logic sdVal);
        i2s_sck = 1'b0;
        i2s_ws  = wsVal;
        i2s_sd  = sdVal;
        #80;
        i2s_sck = 1'b1;
        #80;
    endtask

    // One slot of 'bits' sck cycles; the word's last bit spills into the next slot.
    task automatic applyStimulus(input logic ch, input logic [15:0] slot, input int bits);
        sckCycle(ch, carryBit);
        for (int i = 1; i < bits; i++) sckCycle(ch, slot[16-i]);
        carryBit = slot[16-bits];
    endtask

    task automatic expectWord(input logic ch, input logic [DW-1:0] data);
        exp_t e;
        e.addr = {mPair, ch ^ mSwap};
        e.data = data;
        sb.push_back(e);
        if (e.addr[0]) mPair++;
    endtask

    task automatic trailer(input logic wsVal);
        sckCycle(wsVal, carryBit);
        i2s_sck = 1'b0;
        repeat (8) @(negedge wb_clk);
    endtask

    task automatic preamble(input int cycles);
        for (int i = 0; i < cycles; i++) sckCycle(1'b1, 1'($urandom));
    endtask

    task automatic startRun(input logic [5:0] res, input logic swap);
        @(negedge wb_clk);
        conf_en = 1'b0;
        i2s_ws  = 1'b1;
        i2s_sck = 1'b0;
        repeat (6) @(negedge wb_clk);
        conf_res  = res;
        conf_swap = swap;
        mSwap     = swap;
        mPair     = '0;
        carryBit  = 1'b0;
        sb.delete();
        conf_en   = 1'b1;
        repeat (4) @(negedge wb_clk);
    endtask

    task automatic readAddr(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge wb_clk);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge wb_clk);
        rd_en   = 1'b0;
        d       = sample_dat_o;
    endtask

    task automatic drain(input string tag);
        exp_t          e;
        logic [DW-1:0] d;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            readAddr(e.addr, d);
            checkOutput($sformatf("%s addr%0d", tag, e.addr), 32'(d), 32'(e.data));
        end
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] l, r;
        int            l0, h0;

        wb_rst = 1'b1; conf_res = 6'd16; conf_swap = 1'b0; conf_en = 1'b0;
        i2s_sck = 1'b0; i2s_ws = 1'b1; i2s_sd = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge wb_clk);
        checkOutput("reset sample_dat_o", 32'(sample_dat_o), 0);
        checkOutput("reset wr_ptr_o", 32'(wr_ptr_o), 0);
        checkOutput("reset events", {30'd0, evt_lsbf, evt_hsbf}, 0);
        wb_rst = 1'b0;

        // Nominal stereo frame at full resolution.
        startRun(6'd16, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'hA5C3, 16); expectWord(1'b0, 16'hA5C3);
        applyStimulus(1'b1, 16'h1234, 16); expectWord(1'b1, 16'h1234);
        trailer(1'b0);
        checkOutput("nominal wr_ptr_o", 32'(wr_ptr_o), 2);
        drain("nominal");
        repeat (4) @(negedge wb_clk);
        checkOutput("read hold", 32'(sample_dat_o), 32'h1234);

        // Reduced resolution: trailing slot bits must be ignored.
        startRun(6'd12, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'hABCF, 16); expectWord(1'b0, 16'hABC0);
        applyStimulus(1'b1, 16'h5557, 16); expectWord(1'b1, 16'h5550);
        trailer(1'b0);
        drain("res12");

        startRun(6'd0, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'hBEEF, 16); expectWord(1'b0, 16'hBEEF);
        applyStimulus(1'b1, 16'h0F0F, 16); expectWord(1'b1, 16'h0F0F);
        trailer(1'b0);
        drain("res0");

        // Channel swap puts right at even addresses.
        startRun(6'd16, 1'b1);
        preamble(5);
        applyStimulus(1'b0, 16'hA5C3, 16); expectWord(1'b0, 16'hA5C3);
        applyStimulus(1'b1, 16'h1234, 16); expectWord(1'b1, 16'h1234);
        trailer(1'b0);
        drain("swap");

        // Mid-frame start and a short right slot that must be dropped.
        startRun(6'd16, 1'b0);
        preamble(10);
        checkOutput("startup no write", 32'(wr_ptr_o), 0);
        applyStimulus(1'b0, 16'h1111, 16); expectWord(1'b0, 16'h1111);
        applyStimulus(1'b1, 16'h2200, 8);
        trailer(1'b0);
        checkOutput("short slot wr_ptr_o", 32'(wr_ptr_o), 1);
        drain("short");

        // Sixteen words fill the whole buffer: one half event each, pointer wraps.
        startRun(6'd16, 1'b0);
        preamble(5);
        l0 = lsbfCount;
        h0 = hsbfCount;
        for (int f = 0; f < 8; f++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            applyStimulus(1'b0, l, 16);
            if (f == 4) begin
                repeat (4) @(negedge wb_clk);
                checkOutput("lsbf after 8 words", 32'(lsbfCount - l0), 1);
                checkOutput("no hsbf after 8 words", 32'(hsbfCount - h0), 0);
            end
            expectWord(1'b0, l);
            applyStimulus(1'b1, r, 16);
            expectWord(1'b1, r);
        end
        trailer(1'b0);
        checkOutput("lsbf total", 32'(lsbfCount - l0), 1);
        checkOutput("hsbf total", 32'(hsbfCount - h0), 1);
        checkOutput("event pulse width", 32'(maxRun), 1);
        checkOutput("wrap wr_ptr_o", 32'(wr_ptr_o), 0);
        drain("fill");

        // Dropping the enable mid-word clears the pointer.
        startRun(6'd16, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'h7E81, 16);
        for (int i = 0; i < 8; i++) sckCycle(1'b1, 1'($urandom));
        checkOutput("pre-disable wr_ptr_o", 32'(wr_ptr_o), 1);
        @(negedge wb_clk);
        conf_en = 1'b0;
        repeat (3) @(negedge wb_clk);
        checkOutput("disable wr_ptr_o", 32'(wr_ptr_o), 0);
        checkOutput("disable events", {30'd0, evt_lsbf, evt_hsbf}, 0);
        startRun(6'd16, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'h0F1E, 16); expectWord(1'b0, 16'h0F1E);
        applyStimulus(1'b1, 16'h2D3C, 16); expectWord(1'b1, 16'h2D3C);
        trailer(1'b0);
        drain("after disable");

        // Reset mid-word returns every output to its reset value.
        startRun(6'd16, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'h4455, 16);
        for (int i = 0; i < 8; i++) sckCycle(1'b1, 1'($urandom));
        @(negedge wb_clk);
        wb_rst = 1'b1;
        repeat (2) @(negedge wb_clk);
        checkOutput("midreset sample_dat_o", 32'(sample_dat_o), 0);
        checkOutput("midreset wr_ptr_o", 32'(wr_ptr_o), 0);
        checkOutput("midreset events", {30'd0, evt_lsbf, evt_hsbf}, 0);
        wb_rst = 1'b0;
        startRun(6'd16, 1'b0);
        preamble(5);
        applyStimulus(1'b0, 16'h6677, 16); expectWord(1'b0, 16'h6677);
        applyStimulus(1'b1, 16'h8899, 16); expectWord(1'b1, 16'h8899);
        trailer(1'b0);
        checkOutput("after reset wr_ptr_o", 32'(wr_ptr_o), 2);
        drain("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
